// File: rtl/udp_rx_pkt_buffer_if.sv
// Payload word stream from the GMII UDP receiver into the ping-pong packet buffer.
interface udp_rx_pkt_buffer_if;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_last;
    logic [15:0] wr_byte_len;
    logic [15:0] udp_dst_port;
    logic        rx_abort;

    modport master (
        output wr_data, wr_valid, wr_last, wr_byte_len, udp_dst_port, rx_abort
    );

    modport slave (
        input wr_data, wr_valid, wr_last, wr_byte_len, udp_dst_port, rx_abort
    );
endinterface

// File: rtl/udp_rx_pkt_buffer.sv
// Two-bank ping-pong buffer for received UDP payloads, read in arrival order.
// Optional destination-port filter at commit time: define UDP_PORT_FILTER_EN.
module udp_rx_pkt_buffer #(
    parameter int          ADDR_W      = 9,
    parameter logic [15:0] FILTER_PORT = 16'h1F90
) (
    input  logic                clk,
    input  logic                clr,
    udp_rx_pkt_buffer_if.slave  wr,
    output logic                pkt_avail,
    output logic                pkt_bank,
    output logic [15:0]         pkt_len,
    output logic [ADDR_W:0]     pkt_words,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [31:0]         rd_data,
    input  logic                pkt_release,
    output logic [15:0]         drop_count
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DISCARD} wstate_t;

    wstate_t         state, next_state;
    logic            wr_bank, rd_bank;
    logic [1:0]      full;
    logic [ADDR_W:0] wr_ptr;
    logic [15:0]     len_q   [2];
    logic [ADDR_W:0] words_q [2];
    logic [31:0]     mem     [0:2*DEPTH-1];

    logic mem_we, end_pkt, commit, drop_inc, ptr_inc, ptr_clr, port_ok, release_ok;

`ifdef UDP_PORT_FILTER_EN
    assign port_ok = (wr.udp_dst_port == FILTER_PORT);
`else
    assign port_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= W_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            W_IDLE: begin
                if (wr.wr_valid) begin
                    if (wr.wr_last)        next_state = W_IDLE;
                    else if (full[wr_bank]) next_state = W_DISCARD;
                    else                   next_state = W_FILL;
                end
            end
            W_FILL: begin
                if (wr.rx_abort) begin
                    next_state = W_IDLE;
                end else if (wr.wr_valid) begin
                    if (wr.wr_last)               next_state = W_IDLE;
                    else if (wr_ptr == PTR_FULL)  next_state = W_DISCARD;
                end
            end
            W_DISCARD: begin
                if (wr.rx_abort || (wr.wr_valid && wr.wr_last)) next_state = W_IDLE;
            end
            default: next_state = W_IDLE;
        endcase
    end

    // A word that cannot be stored (no free bank, bank overflow) and carries wr_last ends
    // the discarded packet on the spot, so the next packet is never swallowed.
    always_comb begin
        mem_we   = 1'b0;
        end_pkt  = 1'b0;
        drop_inc = 1'b0;
        ptr_inc  = 1'b0;
        ptr_clr  = 1'b0;
        case (state)
            W_IDLE: begin
                if (wr.wr_valid) begin
                    if (!full[wr_bank]) begin
                        mem_we = 1'b1;
                        if (wr.wr_last) end_pkt = 1'b1;
                        else            ptr_inc = 1'b1;
                    end else if (wr.wr_last) begin
                        drop_inc = 1'b1;
                    end
                end
            end
            W_FILL: begin
                if (wr.rx_abort) begin
                    drop_inc = 1'b1;
                    ptr_clr  = 1'b1;
                end else if (wr.wr_valid) begin
                    if (wr_ptr == PTR_FULL) begin
                        ptr_clr  = 1'b1;
                        drop_inc = wr.wr_last;
                    end else begin
                        mem_we = 1'b1;
                        if (wr.wr_last) end_pkt = 1'b1;
                        else            ptr_inc = 1'b1;
                    end
                end
            end
            W_DISCARD: begin
                if (wr.rx_abort || (wr.wr_valid && wr.wr_last)) drop_inc = 1'b1;
            end
            default: ;
        endcase
        commit = end_pkt & port_ok;
        if (end_pkt && !port_ok) drop_inc = 1'b1;
        if (end_pkt) ptr_clr = 1'b1;
        release_ok = pkt_release & full[rd_bank];
    end

    // A committing bank is always empty and a released bank always full, so both
    // updates to full[] can land in the same cycle without colliding.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr     <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            full       <= 2'b00;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            words_q[0] <= '0;
            words_q[1] <= '0;
            drop_count <= '0;
            rd_data    <= '0;
        end else begin
            if (ptr_clr)      wr_ptr <= '0;
            else if (ptr_inc) wr_ptr <= wr_ptr + 1'b1;
            if (commit) begin
                len_q[wr_bank]   <= wr.wr_byte_len;
                words_q[wr_bank] <= wr_ptr + 1'b1;
                wr_bank          <= ~wr_bank;
            end
            full[0] <= (full[0] & ~(release_ok & ~rd_bank)) | (commit & ~wr_bank);
            full[1] <= (full[1] & ~(release_ok &  rd_bank)) | (commit &  wr_bank);
            if (release_ok) rd_bank <= ~rd_bank;
            if (drop_inc && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            rd_data <= mem[{rd_bank, rd_addr}];
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[{wr_bank, wr_ptr[ADDR_W-1:0]}] <= wr.wr_data;
    end

    assign pkt_avail = full[rd_bank];
    assign pkt_bank  = rd_bank;
    assign pkt_len   = len_q[rd_bank];
    assign pkt_words = words_q[rd_bank];

endmodule

// File: tb/tb_udp_rx_pkt_buffer.sv
// Testbench for udp_rx_pkt_buffer: directed and random packets against a packet-level queue model.
module tb_udp_rx_pkt_buffer;

    localparam int          ADDR_W      = 9;
    localparam int          DEPTH       = 1 << ADDR_W;
    localparam logic [15:0] FILTER_PORT = 16'h1F90;

    logic              clk = 1'b0;
    logic              clr;
    logic              pkt_avail, pkt_bank, pkt_release;
    logic [15:0]       pkt_len, drop_count;
    logic [ADDR_W:0]   pkt_words;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;

    udp_rx_pkt_buffer_if wr_if ();

    udp_rx_pkt_buffer #(.ADDR_W(ADDR_W), .FILTER_PORT(FILTER_PORT)) dut (
        .clk         (clk),
        .clr         (clr),
        .wr          (wr_if),
        .pkt_avail   (pkt_avail),
        .pkt_bank    (pkt_bank),
        .pkt_len     (pkt_len),
        .pkt_words   (pkt_words),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .pkt_release (pkt_release),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference: committed packets queue up in arrival order, each landing in the next bank in turn.
    typedef struct {
        int bank;
        int len;
        int words;
    } pkt_t;

    pkt_t        m_q[$];
    int          m_next_bank;
    int          m_drops;
    logic [31:0] m_mem [2][DEPTH];
    logic [31:0] stash [DEPTH];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_next_bank = 0;
        m_drops     = 0;
    endtask

    task automatic model_drop();
        if (m_drops < 65535) m_drops++;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        int exp_bank;
        exp_bank = (m_q.size() > 0) ? m_q[0].bank : m_next_bank;
        check_output({tag, ".avail"}, 32'(pkt_avail), 32'(m_q.size() > 0));
        check_output({tag, ".bank"}, 32'(pkt_bank), 32'(exp_bank));
        check_output({tag, ".drops"}, 32'(drop_count), 32'(m_drops));
        if (m_q.size() > 0) begin
            check_output({tag, ".len"}, 32'(pkt_len), 32'(m_q[0].len));
            check_output({tag, ".words"}, 32'(pkt_words), 32'(m_q[0].words));
        end
    endtask

    // Drives one packet of n words; abort_at/release_at are word indices (-1 = never).
    task automatic apply_stimulus(input int n, input logic [15:0] blen, input logic [15:0] port,
                                  input int abort_at, input int release_at);
        bit          take;
        bit          aborted;
        bit          port_ok;
        logic [31:0] w;
        take    = 1'b0;
        aborted = 1'b0;
`ifdef UDP_PORT_FILTER_EN
        port_ok = (port == FILTER_PORT);
`else
        port_ok = 1'b1;
`endif
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            wr_if.wr_data      = w;
            wr_if.wr_valid     = 1'b1;
            wr_if.wr_byte_len  = blen;
            wr_if.udp_dst_port = port;
            if (i == abort_at) begin
                wr_if.wr_last  = 1'b0;
                wr_if.rx_abort = 1'b1;
                aborted        = 1'b1;
                tick();
                wr_if.rx_abort = 1'b0;
                break;
            end
            wr_if.wr_last = (i == n - 1);
            if (i == 0) take = (m_q.size() < 2);
            if (i < DEPTH) stash[i] = w;
            pkt_release = (i == release_at);
            tick();
            pkt_release = 1'b0;
            if (i == release_at && m_q.size() > 0) void'(m_q.pop_front());
        end
        wr_if.wr_valid = 1'b0;
        wr_if.wr_last  = 1'b0;
        if (aborted || !take || n > DEPTH || !port_ok) begin
            model_drop();
        end else begin
            for (int i = 0; i < n; i++) m_mem[m_next_bank][i] = stash[i];
            m_q.push_back('{bank: m_next_bank, len: int'(blen), words: n});
            m_next_bank = 1 - m_next_bank;
        end
    endtask

    task automatic release_pkt();
        pkt_release = 1'b1;
        tick();
        pkt_release = 1'b0;
        if (m_q.size() > 0) void'(m_q.pop_front());
    endtask

    task automatic read_check(input string tag, input int count);
        int a;
        if (m_q.size() > 0) begin
            for (int k = 0; k < count; k++) begin
                a = (count >= m_q[0].words) ? (k % m_q[0].words) : $urandom_range(0, m_q[0].words - 1);
                rd_addr = ADDR_W'(a);
                tick();
                check_output({tag, ".rd_data"}, rd_data, m_mem[m_q[0].bank][a]);
            end
        end
    endtask

    function automatic logic [15:0] rand_port();
        return ($urandom_range(0, 7) == 0) ? 16'($urandom) : FILTER_PORT;
    endfunction

    initial begin
        int op, n, ab, rl;
        clr                = 1'b0;
        pkt_release        = 1'b0;
        rd_addr            = '0;
        wr_if.wr_data      = '0;
        wr_if.wr_valid     = 1'b0;
        wr_if.wr_last      = 1'b0;
        wr_if.wr_byte_len  = '0;
        wr_if.udp_dst_port = '0;
        wr_if.rx_abort     = 1'b0;
        model_reset();
        tick();
        tick();

        check_output("reset.avail", 32'(pkt_avail), 32'd0);
        check_output("reset.bank", 32'(pkt_bank), 32'd0);
        check_output("reset.len", 32'(pkt_len), 32'd0);
        check_output("reset.words", 32'(pkt_words), 32'd0);
        check_output("reset.rd_data", rd_data, 32'd0);
        check_output("reset.drops", 32'(drop_count), 32'd0);
        clr = 1'b1;
        tick();

        apply_stimulus(3, 16'd10, FILTER_PORT, -1, -1);
        check_output("first.len", 32'(pkt_len), 32'd10);
        check_output("first.words", 32'(pkt_words), 32'd3);
        check_state("first");
        read_check("first", 3);

        apply_stimulus(4, 16'd15, FILTER_PORT, -1, -1);
        apply_stimulus(2, 16'd7, FILTER_PORT, -1, -1);
        check_state("third_dropped");
        release_pkt();
        check_state("release1");
        read_check("release1", 4);
        release_pkt();
        check_state("release2");
        release_pkt();
        check_state("release_empty");

        apply_stimulus(DEPTH + 1, 16'd2052, FILTER_PORT, -1, -1);
        check_state("overflow");

        apply_stimulus(8, 16'd30, FILTER_PORT, 5, -1);
        check_state("abort");
        apply_stimulus(2, 16'd8, FILTER_PORT, -1, -1);
        check_state("after_abort");

        apply_stimulus(5, 16'd20, FILTER_PORT, -1, -1);
        check_state("both_full");
        apply_stimulus(3, 16'd12, FILTER_PORT, -1, 0);
        check_state("release_vs_first");
        apply_stimulus(3, 16'd11, FILTER_PORT, -1, -1);
        check_state("freed_bank");
        read_check("freed_bank", 5);
        release_pkt();
        check_state("freed_release");
        read_check("freed_release", 3);

        apply_stimulus(3, 16'd9, FILTER_PORT, -1, 2);
        check_state("commit_and_release");
        read_check("commit_and_release", 3);
        release_pkt();

        apply_stimulus(2, 16'd6, 16'h0050, -1, -1);
        check_state("port_0050");
        apply_stimulus(2, 16'd6, FILTER_PORT, -1, -1);
        check_state("port_1f90");

        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 9);
            if (op < 5) begin
                n  = $urandom_range(1, 6);
                ab = (n > 1 && $urandom_range(0, 5) == 0) ? $urandom_range(1, n - 1) : -1;
                rl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
                if (ab >= 0 && rl >= ab) rl = -1;
                apply_stimulus(n, 16'($urandom), rand_port(), ab, rl);
            end else if (op < 8) begin
                release_pkt();
            end else begin
                read_check("rand", 2);
            end
            check_state("rand");
        end

        apply_stimulus(3, 16'd12, FILTER_PORT, 2, -1);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 32'h1234_5678;
        tick();
        tick();
        clr            = 1'b0;
        wr_if.wr_valid = 1'b0;
        model_reset();
        #1;
        check_output("midreset.drops", 32'(drop_count), 32'd0);
        check_output("midreset.avail", 32'(pkt_avail), 32'd0);
        tick();
        clr = 1'b1;
        tick();
        apply_stimulus(2, 16'd5, FILTER_PORT, -1, -1);
        check_state("post_reset");
        read_check("post_reset", 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/udp_rx_pkt_buffer.md
# udp_rx_pkt_buffer

Ping-pong packet buffer directly downstream of the GMII UDP receiver. Collects the 32-bit payload words the receiver emits, commits each complete packet into one of two RAM banks, and presents committed packets in arrival order to the CPU-side consumer through a random-access read port and a release handshake. Packets arriving with no free bank, overflowing a bank, or aborted mid-frame are discarded whole and counted.

## Interface
- ADDR_W, 9, word address width per bank; each bank holds 2^ADDR_W 32-bit words.
- FILTER_PORT, 16'h1F90, UDP destination port accepted when the port filter is compiled in.

- clk  in  1  GMII receive clock; all logic on rising edge.
- clr  in  1  reset, asynchronous, active-low.
- wr_data  in  32  payload word, MSB = first byte on wire.
- wr_valid  in  1  wr_data valid this cycle; one word per high cycle.
- wr_last  in  1  qualified by wr_valid; final word of packet.
- wr_byte_len  in  16  payload byte count; sampled with wr_last.
- udp_dst_port  in  16  UDP destination port; sampled with wr_last.
- rx_abort  in  1  upstream lost the frame; discard the packet in progress.
- pkt_avail  out  1  oldest committed packet ready for reading.
- pkt_bank  out  1  bank index of that packet.
- pkt_len  out  16  its byte length.
- pkt_words  out  ADDR_W+1  its word count.
- rd_addr  in  ADDR_W  word address within bank pkt_bank.
- rd_data  out  32  registered read data.
- pkt_release  in  1  single-cycle pulse: consumer finished with current packet.
- drop_count  out  16  discarded packets, saturating.

## Operation
- Per-bank state: full[b], len[b], words[b]. Write pointer wr_bank, word pointer wr_ptr; read pointer rd_bank.
- Write FSM, states W_IDLE, W_FILL, W_DISCARD:
  - W_IDLE, wr_valid=1: if full[wr_bank]=0, write word at address 0, wr_ptr←1, go W_FILL; else go W_DISCARD.
  - W_FILL, wr_valid=1: if wr_ptr=2^ADDR_W (bank full of words) go W_DISCARD; else write at wr_ptr, wr_ptr+1.
  - Any accepted word with wr_last=1 commits: full[wr_bank]←1, len←wr_byte_len, words←wr_ptr+1, wr_bank toggles, wr_ptr←0, back to W_IDLE. Single-word packet commits directly from W_IDLE.
  - W_DISCARD: ignore words; on wr_valid&wr_last, drop_count+1, go W_IDLE.
  - rx_abort in W_FILL or W_DISCARD: drop_count+1, wr_ptr←0, W_IDLE; no commit. rx_abort wins over same-cycle wr_valid. rx_abort in W_IDLE ignored.
- Read side: pkt_avail=full[rd_bank]; pkt_bank=rd_bank; pkt_len/pkt_words from that bank. pkt_release with pkt_avail=1: full[rd_bank]←0, rd_bank toggles. pkt_release with pkt_avail=0 ignored.
- Banks commit alternately, so read order equals arrival order.
- drop_count saturates at 16'hFFFF.
- wr_byte_len is stored unchecked.

## Timing
- Reset values: pkt_avail 0, pkt_bank 0, pkt_len 0, pkt_words 0, rd_data 0, drop_count 0; FSM W_IDLE, wr_bank 0, rd_bank 0, full 2'b00. RAM contents are not cleared.
- Commit on cycle N → pkt_avail=1 at N+1.
- rd_addr at cycle N → rd_data at N+1 from bank rd_bank.
- Release on cycle N → full cleared and rd_bank toggled at N+1. A first word on the same cycle N still sees the bank full and the packet is discarded.
- Commit and release on the same cycle both take effect.
- Reset mid-packet abandons the packet without counting it.

## Configuration
- UDP_PORT_FILTER_EN defined: at the commit point, if udp_dst_port≠FILTER_PORT, the packet is not committed. drop_count+1, wr_bank unchanged, wr_ptr←0.
- UDP_PORT_FILTER_EN undefined: udp_dst_port is ignored and every complete packet commits.

## Test plan
- After reset, a 3-word packet with wr_byte_len=10 and port 0x1F90 → pkt_avail=1 one cycle after last word, pkt_bank=0, pkt_len=10, pkt_words=3. rd_addr 0..2 returns the words one cycle later.
- Three packets with no release → the first two commit to banks 0 and 1, the third is discarded, drop_count=1. Release → pkt_bank=1. Release again → pkt_avail=0.
- 2^ADDR_W+1 words with last on the final word → discarded, drop_count=1, full unchanged.
- rx_abort after 5 words → no commit, drop_count=1. The next packet lands in bank 0.
- Release on the same cycle as the first word of a packet while both banks are full → that packet is discarded. The following packet commits to the freed bank.
- With UDP_PORT_FILTER_EN, a packet with port 0x0050 → not committed, drop_count=1. A subsequent packet with port 0x1F90 → commits to bank 0.
